bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter for the score/HUD display path. It accepts an unsigned binary value on a start strobe and runs an iterative shift-and-add-3 (double-dabble) conversion, one input bit per clock. It presents `DIGITS` packed BCD nibbles with a done pulse and an overflow flag. It feeds the 7-segment and VGA digit renderers, and supersedes the fixed-width combinational converter.

---
 rtl/bin_to_bcd_pkg.sv | 6 +
 rtl/bin_to_bcd_seq_digit_adj.sv | 7 +
 rtl/bin_to_bcd_seq.sv | 100 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared FSM states and BCD code constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_NINE  = 4'h9;
endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// bcd_digit_adj: double-dabble nibble correction, adds 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble converter, one input bit per clock, with saturating overflow.
// Define BIN_TO_BCD_LZB_EN to blank leading zero digits in the result.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);
    localparam int CW = $clog2(IN_W + 1);
    localparam int BW = 4 * DIGITS;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0] bin_q, bin_d;
    logic [BW-1:0]   scr_q, scr_d, adj, res, bcd_q;
    logic            sov_q, sov_d, ovf_q, done_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (.d_i(scr_q[4*g +: 4]), .d_o(adj[4*g +: 4]));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        sov_d   = sov_q;
        case (state_q)
            SHIFT: begin
                {scr_d, bin_d} = {adj, bin_q} << 1;
                sov_d          = sov_q | adj[BW-1];
                cnt_d          = cnt_q - 1'b1;
                state_d        = (cnt_q == CW'(1)) ? DONE : SHIFT;
            end
            default: begin
                state_d = start ? SHIFT : IDLE;
                if (start) begin
                    bin_d = bin_in;
                    scr_d = '0;
                    cnt_d = CW'(IN_W);
                    sov_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
`ifdef BIN_TO_BCD_LZB_EN
        logic blank;
        res   = scr_q;
        blank = 1'b1;
        // walk down from the top digit; digit 0 always stays visible
        for (int i = DIGITS - 1; i > 0; i--) begin
            blank = blank && (scr_q[4*i +: 4] == 4'h0);
            if (blank) res[4*i +: 4] = BCD_BLANK;
        end
`else
        res = scr_q;
`endif
        if (sov_q) res = {DIGITS{BCD_NINE}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            sov_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            sov_q   <= sov_d;
            done_q  <= (state_q == DONE);
            if (state_q == DONE) begin
                bcd_q <= res;
                ovf_q <= sov_q;
            end
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq at default parameters.
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bin_in = '0;
    logic        busy, done, overflow;
    logic [31:0] bcd_out;
    int          n_chk = 0;
    int          n_fail = 0;

`ifdef BIN_TO_BCD_LZB_EN
    localparam logic [31:0] E5086 = 32'hFFFF5086, E0 = 32'hFFFFFFF0, E7 = 32'hFFFFFFF7;
    localparam logic [31:0] E1234 = 32'hFFFF1234, E42 = 32'hFFFFFF42;
`else
    localparam logic [31:0] E5086 = 32'h00005086, E0 = 32'h00000000, E7 = 32'h00000007;
    localparam logic [31:0] E1234 = 32'h00001234, E42 = 32'h00000042;
`endif

    bin_to_bcd_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] v, output int lat);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start = 1'b0;
        lat   = 61;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, nd, nlow, first, last;
        logic [31:0] got;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_ovf", overflow, 0);

        run(32'd5086, lat);
        check("lat_5086", lat, 33);
        check("bcd_5086", bcd_out, E5086);
        check("ovf_5086", overflow, 0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("bcd_hold", bcd_out, E5086);

        run(32'd0, lat);
        check("bcd_0", bcd_out, E0);
        run(32'd99999999, lat);
        check("bcd_max", bcd_out, 32'h99999999);
        check("ovf_max", overflow, 0);
        run(32'd100000000, lat);
        check("ovf_big", overflow, 1);
        check("bcd_big", bcd_out, 32'h99999999);
        run(32'd7, lat);
        check("ovf_7", overflow, 0);
        check("bcd_7", bcd_out, E7);

        // start while busy must be ignored
        @(negedge clk);
        start  = 1'b1;
        bin_in = 32'd1234;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        lat = 0;
        got = '0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                start  = 1'b1;
                bin_in = 32'd9;
            end
            if (i == 10) start = 1'b0;
            if (i == 5) check("busy_mid", busy, 1);
            if (done) begin
                nd++;
                lat = i;
                got = bcd_out;
            end
        end
        check("ign_ndone", nd, 1);
        check("ign_lat", lat, 33);
        check("ign_bcd", got, E1234);

        // continuous start: back-to-back through the DONE state
        @(negedge clk);
        start  = 1'b1;
        bin_in = 32'd42;
        nd = 0;
        nlow = 0;
        first = 0;
        last = 0;
        @(posedge clk);
        for (int i = 1; i <= 99; i++) begin
            @(posedge clk);
            #1;
            if (!busy) nlow++;
            if (done) begin
                nd++;
                if (first == 0) first = i;
                last = i;
                check("cont_bcd", bcd_out, E42);
            end
        end
        start = 1'b0;
        check("cont_ndone", nd, 3);
        check("cont_first", first, 33);
        check("cont_last", last, 99);
        check("cont_busylow", nlow, 3);

        // async reset in the middle of the conversion started at the last edge
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_bcd", bcd_out, 0);
        check("arst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("arst_nodone", nd, 0);
        run(32'd5086, lat);
        check("post_lat", lat, 33);
        check("post_bcd", bcd_out, E5086);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
